regfile_sb: RTL and testbench

Integer register file with long-latency scoreboard for the RV32 decode stage. Two combinational read ports drive the RD1/RD2 operands that the ID/EX pipeline register captures; one write port receives writeback results. A per-register busy bit tracks destinations of in-flight multi-cycle operations (divide, FP-to-int, AMO). A stall request is raised while a decoded instruction sources a busy register.

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Brief    : RV32 integer register file with two combinational read ports,
//             one write port with write-through bypass, and a per-register
//             busy scoreboard for long-latency destinations (stall + drain).
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WB_LONG,
  input  logic                  ISSUE,
  input  logic [ADDR_WIDTH-1:0] ISSUE_RD,
  input  logic                  USE1,
  input  logic                  USE2,
  output logic                  STALL,
  output logic                  BUSY_ANY
);

  localparam int c_NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_NREGS];
  logic [c_NREGS-1:0]    r_busy;

  logic [c_NREGS-1:0]    w_set_vec;
  logic [c_NREGS-1:0]    w_clr_vec;
  logic [c_NREGS-1:0]    w_busy_eff;
  logic [c_NREGS-1:0]    w_busy_nxt;
  logic                  w_wr_valid;

  assign w_wr_valid = WE3 && (A3 != '0);

  // x0 never becomes busy, so its decode bits are tied off; all other
  // registers get a one-hot set (issue) and clear (long writeback) strobe.
  assign w_set_vec[0] = 1'b0;
  assign w_clr_vec[0] = 1'b0;
  generate
    for (genvar i = 1; i < c_NREGS; i++) begin : g_busy_decode
      assign w_set_vec[i] = ISSUE && (ISSUE_RD == ADDR_WIDTH'(i));
      assign w_clr_vec[i] = WE3 && WB_LONG && (A3 == ADDR_WIDTH'(i));
    end
  endgenerate

  // A completing long write resolves its hazard in the same cycle because
  // the bypass already forwards WD3 to the readers.
  assign w_busy_eff = r_busy & ~w_clr_vec;

  // Set is applied after clear so a new issue to the same rd keeps it busy.
  assign w_busy_nxt = w_busy_eff | w_set_vec;

  // Register array: reset clears everything, writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < c_NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[A3] <= WD3;
    end
  end

  // Busy scoreboard: reset forgets all in-flight long ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Read ports with write-through bypass; x0 always reads as zero.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (w_wr_valid && (A3 == A1)) begin
      RD1 = WD3;
    end else if (A1 != '0) begin
      RD1 = r_regs[A1];
    end
    if (w_wr_valid && (A3 == A2)) begin
      RD2 = WD3;
    end else if (A2 != '0) begin
      RD2 = r_regs[A2];
    end
  end

  // Hazard detection against the effective busy view; drain uses raw busy.
  always_comb begin
    STALL    = (USE1 && w_busy_eff[A1]) || (USE2 && w_busy_eff[A2]);
    BUSY_ANY = |r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Brief    : Self-checking bench for regfile_sb with a behavioural model of
//             register contents and outstanding long-latency destinations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2, a3, issue_rd;
  logic [31:0] rd1, rd2, wd3;
  logic        we3, wb_long, issue, use1, use2;
  logic        stall, busy_any;

  int n_tests;
  int n_fail;

  // Reference model: register values and set of registers awaiting a long op.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .WE3(we3), .A3(a3), .WD3(wd3), .WB_LONG(wb_long),
    .ISSUE(issue), .ISSUE_RD(issue_rd),
    .USE1(use1), .USE2(use2),
    .STALL(stall), .BUSY_ANY(busy_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (we3 && a3 == a && a3 != 5'd0) return wd3;
    if (a == 5'd0) return 32'h0;
    return m_regs[a];
  endfunction

  function automatic logic exp_pending(input logic [4:0] a);
    return m_busy[a] && !(we3 && wb_long && a3 == a);
  endfunction

  function automatic logic exp_stall();
    return (use1 && exp_pending(a1)) || (use2 && exp_pending(a2));
  endfunction

  function automatic logic exp_busy_any();
    for (int r = 0; r < 32; r++) if (m_busy[r]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock: update the model from the inputs present at the edge.
  task automatic tick();
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 32'h0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (we3 && a3 != 5'd0) m_regs[a3] = wd3;
      if (we3 && wb_long) m_busy[a3] = 1'b0;
      if (issue && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 0; wb_long = 0; issue = 0; use1 = 0; use2 = 0;
    a1 = 0; a2 = 0; a3 = 0; issue_rd = 0; wd3 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      a1 = 5'(a); a2 = 5'(31 - a);
      #1;
      n_tests++;
      if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read idx=%0d: got rd1=%h rd2=%h expected 0", a, rd1, rd2);
      end
    end
    n_tests++;
    if (stall !== 1'b0 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got stall=%b busy_any=%b expected 0/0", stall, busy_any);
    end
    // Writing x0 must have no effect, neither bypassed nor stored.
    we3 = 1; a3 = 0; wd3 = 32'hDEADBEEF; a1 = 0;
    #1;
    n_tests++;
    if (rd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_bypass: got %h expected 00000000", rd1);
    end
    tick();
    we3 = 0;
    #1;
    n_tests++;
    if (rd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_write: got %h expected 00000000", rd1);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we3 = 1; a3 = 5; wd3 = 32'h12345678; a1 = 5; a2 = 6;
    #1;
    n_tests++;
    if (rd1 !== 32'h12345678 || rd2 !== exp_rd(5'd6)) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got rd1=%h rd2=%h expected 12345678/%h", rd1, rd2, exp_rd(5'd6));
    end
    tick();
    we3 = 0;
    #1;
    n_tests++;
    if (rd1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bypass_stored: got %h expected 12345678", rd1);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    issue = 1; issue_rd = 7; a1 = 7; use1 = 1;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_not_yet_busy: got stall=%b expected 0", stall);
    end
    tick();
    issue = 0;
    #1;
    n_tests++;
    if (stall !== 1'b1 || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_stall: got stall=%b busy_any=%b expected 1/1", stall, busy_any);
    end
    use1 = 0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL unused_no_stall: got stall=%b expected 0", stall);
    end
    use1 = 1; we3 = 1; wb_long = 1; a3 = 7; wd3 = 32'h000000A5;
    #1;
    n_tests++;
    if (stall !== 1'b0 || rd1 !== 32'h000000A5 || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_long_resolve: got stall=%b rd1=%h busy_any=%b expected 0/000000a5/1",
               stall, rd1, busy_any);
    end
    tick();
    we3 = 0; wb_long = 0;
    #1;
    n_tests++;
    if (busy_any !== 1'b0 || stall !== 1'b0 || rd1 !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL wb_long_cleared: got busy_any=%b stall=%b rd1=%h expected 0/0/000000a5",
               busy_any, stall, rd1);
    end
  endtask

  task automatic test_set_clear_same();
    idle_inputs();
    issue = 1; issue_rd = 9;
    tick();
    we3 = 1; wb_long = 1; a3 = 9; wd3 = 32'h00000099;
    tick();
    idle_inputs();
    a2 = 9; use2 = 1;
    #1;
    n_tests++;
    if (stall !== 1'b1 || rd2 !== 32'h00000099 || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: got stall=%b rd2=%h busy_any=%b expected 1/00000099/1",
               stall, rd2, busy_any);
    end
    use2 = 0; we3 = 1; wb_long = 1; a3 = 9; wd3 = 32'h00000999;
    tick();
    idle_inputs();
  endtask

  task automatic test_plain_write_busy();
    idle_inputs();
    issue = 1; issue_rd = 3;
    tick();
    issue = 0; we3 = 1; a3 = 3; wd3 = 32'h33333333;
    tick();
    we3 = 0; a1 = 3; use1 = 1;
    #1;
    n_tests++;
    if (stall !== 1'b1 || rd1 !== 32'h33333333) begin
      n_fail++;
      $display("FAIL plain_write_keeps_busy: got stall=%b rd1=%h expected 1/33333333", stall, rd1);
    end
    use1 = 0; issue = 1; issue_rd = 0;
    tick();
    issue = 0; a1 = 0; use1 = 1;
    #1;
    n_tests++;
    if (busy_any !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_x0: got busy_any=%b stall=%b expected 1/0", busy_any, stall);
    end
    use1 = 0; we3 = 1; wb_long = 1; a3 = 3; wd3 = 32'h3;
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_after_x3: got busy_any=%b expected 0", busy_any);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    issue = 1; issue_rd = 4;
    tick();
    rst_n = 0; we3 = 1; a3 = 4; wd3 = 32'h44444444; issue = 1; issue_rd = 4;
    tick();
    rst_n = 1;
    idle_inputs();
    a1 = 4; use1 = 1;
    #1;
    n_tests++;
    if (rd1 !== 32'h0 || stall !== 1'b0 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got rd1=%h stall=%b busy_any=%b expected 0/0/0", rd1, stall, busy_any);
    end
    we3 = 1; wb_long = 1; a3 = 4; wd3 = 32'h55555555;
    tick();
    we3 = 0; wb_long = 0;
    #1;
    n_tests++;
    if (rd1 !== 32'h55555555 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_after_reset: got rd1=%h busy_any=%b expected 55555555/0", rd1, busy_any);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      a1       = 5'($urandom_range(0, 31));
      a2       = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      a3       = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
      we3      = 1'($urandom_range(0, 1));
      wb_long  = 1'($urandom_range(0, 1));
      wd3      = $urandom;
      issue    = ($urandom_range(0, 3) == 0);
      issue_rd = ($urandom_range(0, 1) == 0) ? a3 : 5'($urandom_range(0, 31));
      use1     = 1'($urandom_range(0, 1));
      use2     = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (rd1 !== exp_rd(a1)) begin
        n_fail++;
        $display("FAIL rand_rd1 cyc=%0d a1=%0d: got %h expected %h", c, a1, rd1, exp_rd(a1));
      end
      n_tests++;
      if (rd2 !== exp_rd(a2)) begin
        n_fail++;
        $display("FAIL rand_rd2 cyc=%0d a2=%0d: got %h expected %h", c, a2, rd2, exp_rd(a2));
      end
      n_tests++;
      if (stall !== exp_stall()) begin
        n_fail++;
        $display("FAIL rand_stall cyc=%0d: got %b expected %b", c, stall, exp_stall());
      end
      n_tests++;
      if (busy_any !== exp_busy_any()) begin
        n_fail++;
        $display("FAIL rand_busy_any cyc=%0d: got %b expected %b", c, busy_any, exp_busy_any());
      end
      tick();
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 0;
    idle_inputs();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_busy[r] = 1'b0;
    end
    test_reset();
    test_bypass();
    test_scoreboard();
    test_set_clear_same();
    test_plain_write_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
